// File: rtl/seg_scan_ctrl_if.sv
// Update handshake between the price/credit logic (master) and the
// seven-segment scan controller (slave): four 7-bit digit patterns per transfer.
interface seg_scan_ctrl_if;
    logic        valid;
    logic [27:0] data;
    logic        ready;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan of a 4-digit seven-segment display with per-digit blanking,
// PWM brightness, one dead cycle per slot, and frame-synchronised digit updates.
module seg_scan_ctrl #(
    parameter int TICK_DIV = 100000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_enable,
    input  logic [3:0]        i_blank,
    input  logic [3:0]        i_duty,
    seg_scan_ctrl_if.slave    upd,
    output logic [6:0]        o_x1,
    output logic [6:0]        o_x2,
    output logic [6:0]        o_x3,
    output logic [6:0]        o_x4,
    output logic [1:0]        o_sel,
    output logic [3:0]        o_an,
    output logic              o_frame_done
);

    localparam int            PW     = $clog2(TICK_DIV);
    localparam logic [PW-1:0] P_LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] r_presc;
    logic [1:0]    r_sel;
    logic [3:0]    r_pwm;
    logic [3:0]    r_an;
    logic          r_frame_done;
    logic [6:0]    r_x1, r_x2, r_x3, r_x4;
    logic [27:0]   r_shadow;
    logic          r_pending;
    logic          r_ready;

    logic [PW-1:0] w_presc_nx;
    logic [1:0]    w_sel_nx;
    logic [3:0]    w_pwm_nx;
    logic [3:0]    w_an_nx;
    logic          w_tick;
    logic          w_bound;
    logic          w_xfer;
    logic          w_apply;
    logic          w_pwm_on;

    always_comb begin
        w_tick     = (r_presc == P_LAST);
        w_bound    = i_enable && w_tick && (r_sel == 2'd3);
        w_xfer     = upd.valid && r_ready;
        // With the scan stopped no boundary will come, so a pending set goes out at once.
        w_apply    = r_pending && (w_bound || !i_enable);
        w_presc_nx = '0;
        w_sel_nx   = 2'd0;
        w_pwm_nx   = 4'd0;
        if (i_enable) begin
            w_presc_nx = w_tick ? '0 : r_presc + 1'b1;
            w_sel_nx   = w_tick ? r_sel + 2'd1 : r_sel;
            w_pwm_nx   = r_pwm + 4'd1;
        end
        // Anodes are computed from next-state values so the registered an lines up with sel.
        w_pwm_on = (i_duty == 4'hF) || (w_pwm_nx < i_duty);
        w_an_nx  = 4'hF;
        if (i_enable && !i_blank[w_sel_nx] && w_pwm_on && (w_presc_nx != '0))
            w_an_nx[w_sel_nx] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc      <= '0;
            r_sel        <= 2'd0;
            r_pwm        <= 4'd0;
            r_an         <= 4'hF;
            r_frame_done <= 1'b0;
            r_x1         <= 7'h00;
            r_x2         <= 7'h00;
            r_x3         <= 7'h00;
            r_x4         <= 7'h00;
            r_shadow     <= 28'h0;
            r_pending    <= 1'b0;
            r_ready      <= 1'b1;
        end else begin
            r_presc      <= w_presc_nx;
            r_sel        <= w_sel_nx;
            r_pwm        <= w_pwm_nx;
            r_an         <= w_an_nx;
            r_frame_done <= w_bound;
            if (w_xfer)
                r_shadow <= upd.data;
            if (w_apply)
                {r_x4, r_x3, r_x2, r_x1} <= r_shadow;
            if (w_xfer)
                r_pending <= 1'b1;
            else if (w_apply)
                r_pending <= 1'b0;
            // ready drops right after a capture but only returns a cycle after the apply
            r_ready <= w_xfer ? 1'b0 : !r_pending;
        end
    end

    assign upd.ready    = r_ready;
    assign o_x1         = r_x1;
    assign o_x2         = r_x2;
    assign o_x3         = r_x3;
    assign o_x4         = r_x4;
    assign o_sel        = r_sel;
    assign o_an         = r_an;
    assign o_frame_done = r_frame_done;

endmodule
